adc_avg_capture: RTL and testbench

- Downstream consumer of the ADC core.
- Sequences ADC conversions by pulsing its start input.
- Captures each digital_output sample after a fixed conversion latency and accumulates 2^AVG_LOG2 samples.
- Presents the truncated average to the next stage through a valid/ready holding register, with sticky overrun reporting.

---
 rtl/adc_pkg.sv | 22 ++
 rtl/adc_result_buffer.sv | 52 +++++
 rtl/adc_avg_capture.sv | 129 ++++++++++++
 tb/tb_adc_avg_capture.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_pkg.sv
// Shared definitions for the ADC averaging capture block.
// Holds the capture FSM state type, ADC default widths/latency, and the
// accumulator width helper used to size the running sum.
package adc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT,
        CAPTURE
    } adc_cap_state_t;

    localparam int ADC_DATA_W      = 8;
    localparam int ADC_CONV_CYCLES = 8;

    // Summing 2^avg_log2 samples of data_w bits never needs more than
    // data_w + avg_log2 bits.
    function automatic int acc_width(input int data_w, input int avg_log2);
        return data_w + avg_log2;
    endfunction

endpackage

// File: rtl/adc_result_buffer.sv
// Single-entry valid/ready holding register for averaged results, with a
// sticky overrun flag.
// Ports:
//   clk, rst_n         clock, async active-low reset
//   push, push_data    new result from the averager (one-cycle strobe)
//   avg_data/avg_valid held result toward the consumer
//   avg_ready          consumer accepts the held result
//   overrun            sticky: a pushed result was dropped
//   clr_overrun        synchronous clear for overrun (set wins over clear)
module adc_result_buffer #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    output logic [DATA_W-1:0] avg_data,
    output logic              avg_valid,
    input  logic              avg_ready,
    output logic              overrun,
    input  logic              clr_overrun
);

    logic xfer;
    logic drop;

    assign xfer = avg_valid & avg_ready;
    // Buffer is occupied and not draining this cycle: the new result is lost.
    assign drop = push & avg_valid & ~avg_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            avg_data  <= '0;
            avg_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (push && !drop) begin
                // Covers both an empty buffer and a same-cycle transfer.
                avg_data  <= push_data;
                avg_valid <= 1'b1;
            end else if (xfer) begin
                avg_valid <= 1'b0;
            end

            if (drop)
                overrun <= 1'b1;
            else if (clr_overrun)
                overrun <= 1'b0;
        end
    end

endmodule

// File: rtl/adc_avg_capture.sv
// ADC conversion sequencer and sample averager.
// Pulses adc_start, captures adc_data CONV_CYCLES later, accumulates
// 2^AVG_LOG2 samples and hands the truncated mean to a result buffer.
// Ports:
//   clk, rst_n         clock, async active-low reset
//   enable             run continuous conversion bursts while high
//   adc_start          registered one-cycle start pulse to the ADC
//   adc_data           ADC sample input
//   avg_data/avg_valid/avg_ready   result handshake
//   overrun/clr_overrun            sticky dropped-result flag and its clear
//   busy               FSM not idle
module adc_avg_capture
    import adc_pkg::*;
#(
    parameter int DATA_W      = ADC_DATA_W,
    parameter int CONV_CYCLES = ADC_CONV_CYCLES,
    parameter int AVG_LOG2    = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    output logic              adc_start,
    input  logic [DATA_W-1:0] adc_data,
    output logic [DATA_W-1:0] avg_data,
    output logic              avg_valid,
    input  logic              avg_ready,
    output logic              overrun,
    input  logic              clr_overrun,
    output logic              busy
);

    localparam int ACC_W  = acc_width(DATA_W, AVG_LOG2);
    localparam int CNT_W  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int WAIT_W = (CONV_CYCLES > 2) ? $clog2(CONV_CYCLES - 1) : 1;

    localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'((1 << AVG_LOG2) - 1);
    // START plus (CONV_CYCLES-1) WAIT cycles puts CAPTURE at start+CONV_CYCLES.
    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(CONV_CYCLES - 2);

    adc_cap_state_t    state;
    logic [WAIT_W-1:0] wait_cnt;
    logic [CNT_W-1:0]  sample_cnt;
    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  sum;
    logic              last;
    logic              push;
    logic [DATA_W-1:0] push_data;

    assign sum  = acc + ACC_W'(adc_data);
    assign last = (sample_cnt == LAST_CNT);
    // A capture in a cycle where enable has dropped is discarded.
    assign push      = (state == CAPTURE) && enable && last;
    assign push_data = sum[ACC_W-1:AVG_LOG2];
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            adc_start  <= 1'b0;
            wait_cnt   <= '0;
            sample_cnt <= '0;
            acc        <= '0;
        end else begin
            adc_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable) begin
                        state     <= START;
                        adc_start <= 1'b1;
                    end
                end
                START: begin
                    if (!enable) begin
                        state      <= IDLE;
                        acc        <= '0;
                        sample_cnt <= '0;
                    end else begin
                        wait_cnt <= WAIT_LOAD;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (!enable) begin
                        state      <= IDLE;
                        acc        <= '0;
                        sample_cnt <= '0;
                    end else if (wait_cnt == '0) begin
                        state <= CAPTURE;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                CAPTURE: begin
                    if (!enable) begin
                        state      <= IDLE;
                        acc        <= '0;
                        sample_cnt <= '0;
                    end else begin
                        if (last) begin
                            acc        <= '0;
                            sample_cnt <= '0;
                        end else begin
                            acc        <= sum;
                            sample_cnt <= sample_cnt + 1'b1;
                        end
                        state     <= START;
                        adc_start <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    adc_result_buffer #(
        .DATA_W(DATA_W)
    ) u_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .push_data  (push_data),
        .avg_data   (avg_data),
        .avg_valid  (avg_valid),
        .avg_ready  (avg_ready),
        .overrun    (overrun),
        .clr_overrun(clr_overrun)
    );

endmodule

// File: tb/tb_adc_avg_capture.sv
// Scoreboard bench for adc_avg_capture: expected results are queued as
// stimulus is issued; a monitor pops and compares on every transfer.
module tb_adc_avg_capture;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       enable = 1'b0;
    logic       avg_ready = 1'b0;
    logic       clr_overrun = 1'b0;
    logic [7:0] adc_data = 8'h00;
    logic       adc_start;
    logic [7:0] avg_data;
    logic       avg_valid;
    logic       overrun;
    logic       busy;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int n_starts = 0;
    logic [7:0] samp_q[$];
    logic [7:0] exp_q[$];

    adc_avg_capture #(
        .DATA_W(8),
        .CONV_CYCLES(8),
        .AVG_LOG2(2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .adc_start  (adc_start),
        .adc_data   (adc_data),
        .avg_data   (avg_data),
        .avg_valid  (avg_valid),
        .avg_ready  (avg_ready),
        .overrun    (overrun),
        .clr_overrun(clr_overrun),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // ADC model: each start loads the next queued sample, held until the
    // next start, so it is stable well before the capture edge.
    always @(posedge clk) begin
        if (adc_start) begin
            n_starts <= n_starts + 1;
            if (samp_q.size() > 0)
                adc_data <= samp_q.pop_front();
            else
                adc_data <= 8'h00;
        end
    end

    // Monitor: a transfer happens at the posedge following this sample point.
    always @(negedge clk) begin
        if (rst_n && avg_valid && avg_ready) begin
            n_cmp = n_cmp + 1;
            if (exp_q.size() == 0) begin
                n_err = n_err + 1;
                $display("FAIL xfer_unexpected: got %h, none expected", avg_data);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (avg_data !== e) begin
                    n_err = n_err + 1;
                    $display("FAIL xfer_data: got %h, expected %h", avg_data, e);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // sel: 0 avg_valid, 1 adc_start, 2 overrun
    task automatic wait_for(input int sel, input string nm);
        int  k;
        bit  hit;
        k = 0;
        hit = 1'b0;
        do begin
            @(negedge clk);
            k++;
            case (sel)
                0: hit = avg_valid;
                1: hit = adc_start;
                default: hit = overrun;
            endcase
        end while (!hit && k < 500);
        if (!hit) begin
            n_cmp = n_cmp + 1;
            n_err = n_err + 1;
            $display("FAIL timeout_%s: got no event, expected one within 500 cycles", nm);
        end
    endtask

    task automatic push4(input logic [7:0] a, b, c, d);
        samp_q.push_back(a);
        samp_q.push_back(b);
        samp_q.push_back(c);
        samp_q.push_back(d);
    endtask

    task automatic run_burst(input logic [7:0] a, b, c, d, input logic [7:0] e, input string nm);
        samp_q.delete();
        push4(a, b, c, d);
        exp_q.push_back(e);
        enable = 1'b1;
        wait_for(0, nm);
        enable = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int s, st0;
        logic [7:0] x;

        // Reset state
        #2 rst_n = 1'b0;
        #1;
        chk("rst_adc_start", adc_start, 0);
        chk("rst_busy", busy, 0);
        chk("rst_avg_valid", avg_valid, 0);
        chk("rst_avg_data", avg_data, 0);
        chk("rst_overrun", overrun, 0);
        avg_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Basic average with start spacing and result latency
        samp_q.delete();
        push4(8'h10, 8'h20, 8'h30, 8'h40);
        exp_q.push_back(8'h28);
        enable = 1'b1;
        wait_for(1, "first_start");
        s = cyc;
        st0 = n_starts;
        wait_for(0, "basic_valid");
        chk("basic_latency", cyc - s, 36);
        chk("basic_starts", n_starts - st0, 4);
        enable = 1'b0;
        repeat (4) @(negedge clk);

        // Truncation and full scale
        run_burst(8'h01, 8'h01, 8'h01, 8'h02, 8'h01, "trunc_valid");
        run_burst(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, "full_valid");

        // Backpressure: second result dropped, overrun set and cleared
        @(posedge clk); #1 avg_ready = 1'b0;
        samp_q.delete();
        push4(8'h10, 8'h20, 8'h30, 8'h40);
        push4(8'h50, 8'h50, 8'h50, 8'h50);
        exp_q.push_back(8'h28);
        enable = 1'b1;
        wait_for(2, "overrun_set");
        enable = 1'b0;
        @(negedge clk);
        chk("bp_hold_data", avg_data, 8'h28);
        chk("bp_hold_valid", avg_valid, 1);
        chk("bp_overrun", overrun, 1);
        clr_overrun = 1'b1;
        @(negedge clk);
        clr_overrun = 1'b0;
        chk("bp_overrun_clr", overrun, 0);
        chk("bp_valid_after_clr", avg_valid, 1);
        @(posedge clk); #1 avg_ready = 1'b1;
        @(negedge clk);
        @(posedge clk); #1 avg_ready = 1'b0;
        @(negedge clk);
        chk("bp_drained", avg_valid, 0);

        // Simultaneous new result and transfer
        samp_q.delete();
        push4(8'h10, 8'h20, 8'h30, 8'h40);
        push4(8'h60, 8'h60, 8'h60, 8'h60);
        exp_q.push_back(8'h28);
        exp_q.push_back(8'h60);
        enable = 1'b1;
        wait_for(0, "sim_first");
        repeat (34) @(negedge clk);
        @(posedge clk); #1 avg_ready = 1'b1;
        @(posedge clk); #1 avg_ready = 1'b0;
        @(negedge clk);
        enable = 1'b0;
        chk("sim_data", avg_data, 8'h60);
        chk("sim_valid", avg_valid, 1);
        chk("sim_overrun", overrun, 0);
        @(posedge clk); #1 avg_ready = 1'b1;
        repeat (4) @(negedge clk);

        // Enable drop after the second capture
        samp_q.delete();
        samp_q.push_back(8'h11);
        samp_q.push_back(8'h22);
        enable = 1'b1;
        wait_for(1, "drop_start");
        repeat (18) @(negedge clk);
        chk("drop_restart", adc_start, 1);
        enable = 1'b0;
        st0 = n_starts;
        @(negedge clk);
        chk("drop_idle", busy, 0);
        repeat (20) @(negedge clk);
        chk("drop_no_start", n_starts - st0, 1);
        chk("drop_no_result", avg_valid, 0);
        run_burst(8'h80, 8'h80, 8'h80, 8'h80, 8'h80, "reen_valid");

        // Reset mid-WAIT with a pending result
        @(posedge clk); #1 avg_ready = 1'b0;
        samp_q.delete();
        push4(8'h44, 8'h44, 8'h44, 8'h44);
        enable = 1'b1;
        wait_for(0, "rst_pending");
        repeat (3) @(negedge clk);
        chk("pre_rst_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", avg_valid, 0);
        chk("mid_rst_data", avg_data, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_start", adc_start, 0);
        chk("mid_rst_overrun", overrun, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_start", adc_start, 1);
        chk("post_rst_busy", busy, 1);
        // Async reset must drop the start pulse without a clock edge.
        rst_n = 1'b0;
        #1;
        x = {7'd0, adc_start};
        chk("async_start_drop", x, 0);
        enable = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        avg_ready = 1'b1;
        repeat (4) @(negedge clk);

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
